// File: rtl/key_event_detect.sv
// rtl/key_event_detect.sv - debounced active-low key with press/release/short/long/repeat pulses
module key_event_detect #(
    parameter int CNT_MAX    = 1_000_000,
    parameter int LONG_MAX   = 50_000_000,
    parameter int REPEAT_MAX = 10_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_value,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int HOLD_MAX = (LONG_MAX > REPEAT_MAX) ? LONG_MAX : REPEAT_MAX;
    localparam int DW       = $clog2(CNT_MAX);
    localparam int HW       = $clog2(HOLD_MAX);

    localparam logic [DW-1:0] DEB_LAST    = DW'(CNT_MAX - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_MAX - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_MAX - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LONG = 2'd2;

    logic          key_s1_q, key_s2_q;
    logic          key_value_q, key_value_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          fall, rise;

    // Two-flop synchroniser for the asynchronous key pin; idles at released level
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
        end
    end

    // Debounce: the synchronised level must differ from the stable level for a full window
    always_comb begin
        key_value_d = key_value_q;
        deb_cnt_d   = deb_cnt_q;
        if (key_s2_q == key_value_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            key_value_d = key_s2_q;
            deb_cnt_d   = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Edges are taken from the next stable level so pulses land on the same edge key_value moves
    assign fall = key_value_q & ~key_value_d;
    assign rise = ~key_value_q & key_value_d;

    // Event FSM: release always wins over a long/repeat terminal count in the same cycle
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = HELD;
                end
            end
            HELD: begin
                if (rise) begin
                    release_d  = 1'b1;
                    short_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else if (hold_cnt_q == LONG_LAST) begin
                    long_d     = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (rise) begin
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else if (hold_cnt_q == REPEAT_LAST) begin
                    repeat_d   = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                hold_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // State, counters and registered one-cycle pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_value_q <= 1'b1;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            state_q     <= IDLE;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            key_value_q <= key_value_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign key_value     = key_value_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_event_detect.sv
// tb/tb_key_event_detect.sv - scoreboard bench for key_event_detect
module tb_key_event_detect;

    localparam int CNT_MAX    = 5;
    localparam int LONG_MAX   = 20;
    localparam int REPEAT_MAX = 8;
    localparam int DEB_LAT    = CNT_MAX + 2;

    localparam logic [4:0] EV_PRESS = 5'b10000;
    localparam logic [4:0] EV_REL   = 5'b01000;
    localparam logic [4:0] EV_SHORT = 5'b00100;
    localparam logic [4:0] EV_LONG  = 5'b00010;
    localparam logic [4:0] EV_REP   = 5'b00001;

    typedef struct {
        int unsigned c;
        logic [4:0]  v;
    } ev_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key     = 1'b1;
    logic key_value, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;
    logic [4:0] out_v;

    int unsigned cyc = 0;
    int checks   = 0;
    int failures = 0;
    ev_t exp_q[$];

    key_event_detect #(
        .CNT_MAX    (CNT_MAX),
        .LONG_MAX   (LONG_MAX),
        .REPEAT_MAX (REPEAT_MAX)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .key           (key),
        .key_value     (key_value),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    assign out_v = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Scoreboard: every pulse must match the expected event for this cycle
    always @(negedge sys_clk) begin
        if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            checks++;
            if (out_v !== exp_q[0].v) begin
                failures++;
                $display("FAIL scoreboard cyc=%0d got=%b expected=%b", cyc, out_v, exp_q[0].v);
            end
            void'(exp_q.pop_front());
        end else if (out_v !== 5'b0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d got=%b expected=00000", cyc, out_v);
        end
    end

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (15) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key     = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (key_value !== 1'b1) begin
            failures++;
            $display("FAIL reset_key_value got=%b expected=1", key_value);
        end
        checks++;
        if (out_v !== 5'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b expected=00000", out_v);
        end
        sys_rst = 1'b0;
        repeat (12) @(negedge sys_clk);
        checks++;
        if (key_value !== 1'b1) begin
            failures++;
            $display("FAIL idle_key_value got=%b expected=1", key_value);
        end
    endtask

    task automatic test_clean_press();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + DEB_LAT;
        key = 1'b0;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + 20, EV_LONG});
        exp_q.push_back('{p + 28, EV_REP});
        exp_q.push_back('{p + 36, EV_REP});
        exp_q.push_back('{p + 40, EV_REL});
        wait_until(p - 1);
        checks++;
        if (key_value !== 1'b1) begin
            failures++;
            $display("FAIL clean_before_latency got=%b expected=1", key_value);
        end
        wait_until(p);
        checks++;
        if (key_value !== 1'b0) begin
            failures++;
            $display("FAIL clean_key_value got=%b expected=0", key_value);
        end
        wait_until(t + 40);
        key = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL clean_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + 8 + DEB_LAT;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + 8, EV_REL | EV_SHORT});
        for (int i = 0; i < 5; i++) begin
            key = ((i % 2) == 1);
            wait_until(t + 2 * (i + 1));
        end
        checks++;
        if (key_value !== 1'b1) begin
            failures++;
            $display("FAIL bounce_key_value got=%b expected=1", key_value);
        end
        wait_until(p);
        checks++;
        if (key_value !== 1'b0) begin
            failures++;
            $display("FAIL bounce_settled got=%b expected=0", key_value);
        end
        wait_until(p + 1);
        key = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bounce_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_short_click();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + DEB_LAT;
        key = 1'b0;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + 17, EV_REL | EV_SHORT});
        wait_until(p + 10);
        key = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL short_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_long_repeat();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + DEB_LAT;
        key = 1'b0;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + LONG_MAX, EV_LONG});
        exp_q.push_back('{p + LONG_MAX + REPEAT_MAX, EV_REP});
        exp_q.push_back('{p + LONG_MAX + 2 * REPEAT_MAX, EV_REP});
        exp_q.push_back('{p + LONG_MAX + 3 * REPEAT_MAX, EV_REP});
        exp_q.push_back('{p + 45, EV_REL});
        wait_until(p + 38);
        key = 1'b1;
        wait_until(p + 45);
        checks++;
        if (key_value !== 1'b1) begin
            failures++;
            $display("FAIL long_release_level got=%b expected=1", key_value);
        end
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL long_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_long_collision();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + DEB_LAT;
        key = 1'b0;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + LONG_MAX, EV_REL | EV_SHORT});
        wait_until(p + LONG_MAX - DEB_LAT);
        key = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL long_collision_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_repeat_collision();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + DEB_LAT;
        key = 1'b0;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + LONG_MAX, EV_LONG});
        exp_q.push_back('{p + LONG_MAX + REPEAT_MAX, EV_REL});
        wait_until(p + LONG_MAX + REPEAT_MAX - DEB_LAT);
        key = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL repeat_collision_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        int unsigned t, p;
        @(negedge sys_clk);
        t = cyc;
        p = t + DEB_LAT;
        key = 1'b0;
        exp_q.push_back('{p, EV_PRESS});
        exp_q.push_back('{p + LONG_MAX, EV_LONG});
        exp_q.push_back('{p + 26 + DEB_LAT, EV_PRESS});
        exp_q.push_back('{p + 34 + DEB_LAT, EV_REL | EV_SHORT});
        wait_until(p + 24);
        sys_rst = 1'b1;
        for (int i = 25; i <= 26; i++) begin
            wait_until(p + i);
            checks++;
            if (key_value !== 1'b1) begin
                failures++;
                $display("FAIL midreset_key_value cyc=%0d got=%b expected=1", cyc, key_value);
            end
            checks++;
            if (out_v !== 5'b0) begin
                failures++;
                $display("FAIL midreset_pulses cyc=%0d got=%b expected=00000", cyc, out_v);
            end
        end
        sys_rst = 1'b0;
        wait_until(p + 26 + DEB_LAT - 1);
        checks++;
        if (key_value !== 1'b1) begin
            failures++;
            $display("FAIL midreset_relatch_early got=%b expected=1", key_value);
        end
        wait_until(p + 34);
        key = 1'b1;
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_pending got=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_click();
        test_long_repeat();
        test_long_collision();
        test_repeat_collision();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
